// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: major opcodes and load funct3 selectors.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Combinational load-data extraction: picks byte/half/word from a read word by
// address offset and sign- or zero-extends it. Shared with the MEM stage.
module load_extract
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] d,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned,
    output logic            bad_funct3
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = d[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = d[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = byte_lane[off];
    assign half_sel = half_lane[off[1]];

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = off[0];
            end
            F3_LW: begin
                data       = d;
                misaligned = (off != 2'b00);
            end
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered RV32I writeback stage: WB pipeline register with stall/flush,
// load extraction, regfile write, EX forwarding, next_pc and error flags.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module wb_stage_pipe
    import rv32i_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  valid_in,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]       c,
    input  logic [XLEN-1:0]       d,
    input  logic [XLEN-1:0]       pc_from_mem,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wr_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data,
    output logic [XLEN-1:0]       next_pc,
    output logic                  misalign_err,
    output logic                  illegal_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           instret
`endif
);

    logic                  valid_q;
    logic [6:0]            opcode_q;
    logic [2:0]            funct3_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       c_q;
    logic [XLEN-1:0]       d_q;
    logic [XLEN-1:0]       pc_q;

    // Flush only needs to clear valid_q; payload fields are left as they are.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            c_q      <= '0;
            d_q      <= '0;
            pc_q     <= '0;
        end else if (flush_in) begin
            valid_q <= 1'b0;
        end else if (!stall_in) begin
            valid_q  <= valid_in;
            opcode_q <= opcode;
            funct3_q <= funct3;
            rd_q     <= rd;
            c_q      <= c;
            d_q      <= d;
            pc_q     <= pc_from_mem;
        end
    end

    logic [XLEN-1:0] ld_data;
    logic            ld_misaligned;
    logic            ld_bad_funct3;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .d          (d_q),
        .off        (c_q[1:0]),
        .funct3     (funct3_q),
        .data       (ld_data),
        .misaligned (ld_misaligned),
        .bad_funct3 (ld_bad_funct3)
    );

    logic            class_writes;
    logic            opc_known;
    logic            is_load;
    logic [XLEN-1:0] wb_data;

    always_comb begin
        class_writes = 1'b0;
        opc_known    = 1'b1;
        is_load      = 1'b0;
        wb_data      = c_q;
        case (opcode_q)
            OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: class_writes = 1'b1;
            OPC_JAL, OPC_JALR: begin
                class_writes = 1'b1;
                wb_data      = pc_q + XLEN'(PC_STEP);
            end
            OPC_LOAD: begin
                is_load      = 1'b1;
                class_writes = 1'b1;
                wb_data      = ld_data;
            end
            OPC_BRANCH, OPC_STORE: class_writes = 1'b0;
            default: opc_known = 1'b0;
        endcase
    end

    assign misalign_err = valid_q && is_load && ld_misaligned;
    assign illegal_err  = valid_q && (!opc_known || (is_load && ld_bad_funct3));
    // x0 writes are dropped silently; errored entries never reach the regfile.
    assign wr_en        = valid_q && class_writes && !misalign_err && !illegal_err
                          && (rd_q != '0);
    assign wr_addr      = rd_q;
    assign wr_data      = wb_data;
    assign fwd_valid    = wr_en;
    assign fwd_rd       = rd_q;
    assign fwd_data     = wb_data;
    assign next_pc      = c_q;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (valid_q && !stall_in && !flush_in && !misalign_err && !illegal_err) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: directed scenarios plus a randomized
// run against a behavioural model of the writeback rules.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        valid_in = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] c = '0;
    logic [31:0] d = '0;
    logic [31:0] pc_from_mem = '0;
    logic        wr_en, fwd_valid, misalign_err, illegal_err;
    logic [4:0]  wr_addr, fwd_rd;
    logic [31:0] wr_data, fwd_data, next_pc;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    wb_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .flush_in     (flush_in),
        .valid_in     (valid_in),
        .opcode       (opcode),
        .funct3       (funct3),
        .rd           (rd),
        .c            (c),
        .d            (d),
        .pc_from_mem  (pc_from_mem),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .next_pc      (next_pc),
        .misalign_err (misalign_err),
        .illegal_err  (illegal_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic        mis;
        logic        ill;
    } exp_t;

    // Writeback rules computed with plain arithmetic on the instruction fields.
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f,
                                   input logic [4:0] r, input logic [31:0] cv,
                                   input logic [31:0] dv, input logic [31:0] pv);
        exp_t m;
        int unsigned off, b, h;
        logic writes;
        m = '0;
        writes = 1'b0;
        off = cv % 4;
        b = (dv >> (8 * off)) & 32'hFF;
        h = (dv >> (16 * (off / 2))) & 32'hFFFF;
        if (o == 7'b0110111 || o == 7'b0010111 || o == 7'b0010011 || o == 7'b0110011) begin
            writes = 1'b1; m.data = cv;
        end else if (o == 7'b1101111 || o == 7'b1100111) begin
            writes = 1'b1; m.data = pv + 32'd4;
        end else if (o == 7'b0000011) begin
            writes = 1'b1;
            case (f)
                3'd0: m.data = (b >= 128) ? (b | 32'hFFFFFF00) : b;
                3'd4: m.data = b;
                3'd1: begin m.data = (h >= 32768) ? (h | 32'hFFFF0000) : h; m.mis = (off % 2) != 0; end
                3'd5: begin m.data = h; m.mis = (off % 2) != 0; end
                3'd2: begin m.data = dv; m.mis = (off != 0); end
                default: m.ill = 1'b1;
            endcase
        end else if (o != 7'b1100011 && o != 7'b0100011) begin
            m.ill = 1'b1;
        end
        m.we = writes && !m.mis && !m.ill && (r != 0);
        return m;
    endfunction

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f,
                         input logic [4:0] r, input logic [31:0] cv,
                         input logic [31:0] dv, input logic [31:0] pv);
        valid_in = v; opcode = o; funct3 = f; rd = r; c = cv; d = dv; pc_from_mem = pv;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({wr_en, fwd_valid, misalign_err, illegal_err, wr_addr, fwd_rd, wr_data, fwd_data, next_pc} !== '0)
            $display("FAIL reset_outputs got en=%b fv=%b mis=%b ill=%b addr=%0d data=%h npc=%h want all 0",
                     wr_en, fwd_valid, misalign_err, illegal_err, wr_addr, wr_data, next_pc);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_opcode_sweep();
        logic [6:0]  opcs [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        logic        we_x [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
        logic [31:0] dt_x [9] = '{1, 1, 8, 8, 0, 0, 0, 1, 1};
        logic        mis_x[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, opcs[i], 3'b010, 5'd3, 32'd1, 32'd2, 32'd4);
            step();
            total_cnt++;
            if (wr_en !== we_x[i] || misalign_err !== mis_x[i] || illegal_err !== 1'b0)
                $display("FAIL sweep_flags opc=%b got en=%b mis=%b ill=%b want en=%b mis=%b ill=0",
                         opcs[i], wr_en, misalign_err, illegal_err, we_x[i], mis_x[i]);
            else pass_cnt++;
            if (we_x[i]) begin
                total_cnt++;
                if (wr_data !== dt_x[i] || wr_addr !== 5'd3)
                    $display("FAIL sweep_data opc=%b got %h@%0d want %h@3", opcs[i], wr_data, wr_addr, dt_x[i]);
                else pass_cnt++;
            end
            total_cnt++;
            if (next_pc !== 32'd1) $display("FAIL sweep_next_pc got %h want 1", next_pc);
            else pass_cnt++;
            $display("sweep: opc=%b en=%b data=%h mis=%b", opcs[i], wr_en, wr_data, misalign_err);
        end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3s [8] = '{0, 0, 0, 0, 4, 1, 5, 2};
        logic [31:0] cs  [8] = '{0, 1, 2, 3, 3, 2, 0, 0};
        logic [31:0] ex  [8] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                                 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 7'b0000011, f3s[i], 5'd3, cs[i], 32'h80FF7F01, 32'h100);
            step();
            total_cnt++;
            if (wr_en !== 1'b1 || wr_data !== ex[i] || fwd_data !== ex[i])
                $display("FAIL load_extract f3=%0d c=%0d got en=%b %h want en=1 %h", f3s[i], cs[i], wr_en, wr_data, ex[i]);
            else pass_cnt++;
            $display("load: f3=%0d c=%0d data=%h", f3s[i], cs[i], wr_data);
        end
    endtask

    task automatic test_errors();
        drive(1'b1, 7'b0000011, 3'b001, 5'd3, 32'd1, 32'h80FF7F01, 32'h0);
        step();
        total_cnt++;
        if (misalign_err !== 1'b1 || wr_en !== 1'b0 || illegal_err !== 1'b0)
            $display("FAIL lh_misalign got mis=%b en=%b ill=%b want 1 0 0", misalign_err, wr_en, illegal_err);
        else pass_cnt++;
        drive(1'b1, 7'b0001111, 3'b000, 5'd3, 32'd0, 32'h0, 32'h0);
        step();
        total_cnt++;
        if (illegal_err !== 1'b1 || wr_en !== 1'b0)
            $display("FAIL bad_opcode got ill=%b en=%b want 1 0", illegal_err, wr_en);
        else pass_cnt++;
        drive(1'b1, 7'b0000011, 3'b011, 5'd3, 32'd0, 32'h0, 32'h0);
        step();
        total_cnt++;
        if (illegal_err !== 1'b1 || wr_en !== 1'b0 || misalign_err !== 1'b0)
            $display("FAIL bad_funct3 got ill=%b en=%b mis=%b want 1 0 0", illegal_err, wr_en, misalign_err);
        else pass_cnt++;
        $display("errors: misalign, illegal opcode, illegal funct3 checked");
    endtask

    task automatic test_x0();
        drive(1'b1, 7'b0110011, 3'b000, 5'd0, 32'd5, 32'h0, 32'h0);
        step();
        total_cnt++;
        if (wr_en !== 1'b0 || fwd_valid !== 1'b0 || misalign_err !== 1'b0 || illegal_err !== 1'b0)
            $display("FAIL x0_write got en=%b fv=%b mis=%b ill=%b want 0 0 0 0", wr_en, fwd_valid, misalign_err, illegal_err);
        else pass_cnt++;
        $display("x0: en=%b", wr_en);
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 7'b0110011, 3'b000, 5'd7, 32'd9, 32'h0, 32'h0);
        step();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'b0010011, 3'b000, 5'($urandom_range(1, 31)), $urandom, $urandom, $urandom);
            step();
            total_cnt++;
            if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'd9 || next_pc !== 32'd9)
                $display("FAIL stall_hold cyc=%0d got en=%b %h@%0d want 1 9@7", i, wr_en, wr_data, wr_addr);
            else pass_cnt++;
            $display("stall: cyc=%0d en=%b addr=%0d data=%h", i, wr_en, wr_addr, wr_data);
        end
        flush_in = 1'b1;
        step();
        total_cnt++;
        if (wr_en !== 1'b0 || fwd_valid !== 1'b0)
            $display("FAIL flush_over_stall got en=%b fv=%b want 0 0", wr_en, fwd_valid);
        else pass_cnt++;
        flush_in = 1'b0;
        stall_in = 1'b0;
        $display("flush: en=%b", wr_en);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 7'b0110011, 3'b000, 5'd7, 32'd9, 32'h0, 32'h20);
        step();
        total_cnt++;
        if (wr_en !== 1'b1) $display("FAIL areset_pre got en=%b want 1", wr_en);
        else pass_cnt++;
        stall_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({wr_en, fwd_valid, misalign_err, illegal_err, wr_addr, fwd_rd, wr_data, fwd_data, next_pc} !== '0)
            $display("FAIL areset_mid got en=%b addr=%0d data=%h npc=%h want all 0", wr_en, wr_addr, wr_data, next_pc);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        stall_in = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        $display("async reset: outputs cleared mid-cycle");
    endtask

    task automatic test_random();
        logic [6:0]  opcs [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1111111};
        logic        e_v = 1'b0;
        logic [6:0]  e_o = '0;
        logic [2:0]  e_f = '0;
        logic [4:0]  e_r = '0;
        logic [31:0] e_c = '0, e_d = '0, e_p = '0;
        logic        nv, st, fl;
        logic [6:0]  no;
        logic [2:0]  nf;
        logic [4:0]  nr;
        logic [31:0] nc, nd, np;
        exp_t        m;
        int          errs_before;
        for (int i = 0; i < 300; i++) begin
            nv = ($urandom_range(0, 9) != 0);
            no = (i % 5 == 0) ? 7'($urandom) : opcs[$urandom_range(0, 10)];
            nf = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
            nr = 5'($urandom);
            nc = $urandom; nd = $urandom; np = $urandom;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            drive(nv, no, nf, nr, nc, nd, np);
            stall_in = st;
            flush_in = fl;
            step();
            if (fl) e_v = 1'b0;
            else if (!st) begin
                e_v = nv; e_o = no; e_f = nf; e_r = nr; e_c = nc; e_d = nd; e_p = np;
            end
            errs_before = total_cnt - pass_cnt;
            if (e_v) begin
                m = model(e_o, e_f, e_r, e_c, e_d, e_p);
                total_cnt++;
                if (wr_en !== m.we || fwd_valid !== m.we || misalign_err !== m.mis || illegal_err !== m.ill)
                    $display("FAIL rand_flags i=%0d opc=%b f3=%0d got en=%b mis=%b ill=%b want en=%b mis=%b ill=%b",
                             i, e_o, e_f, wr_en, misalign_err, illegal_err, m.we, m.mis, m.ill);
                else pass_cnt++;
                total_cnt++;
                if (next_pc !== e_c) $display("FAIL rand_next_pc i=%0d got %h want %h", i, next_pc, e_c);
                else pass_cnt++;
                if (m.we) begin
                    total_cnt++;
                    if (wr_data !== m.data || fwd_data !== m.data || wr_addr !== e_r || fwd_rd !== e_r)
                        $display("FAIL rand_data i=%0d got %h@%0d want %h@%0d", i, wr_data, wr_addr, m.data, e_r);
                    else pass_cnt++;
                end
            end else begin
                total_cnt++;
                if (wr_en !== 1'b0 || misalign_err !== 1'b0 || illegal_err !== 1'b0)
                    $display("FAIL rand_idle i=%0d got en=%b mis=%b ill=%b want 0", i, wr_en, misalign_err, illegal_err);
                else pass_cnt++;
            end
            $display("rand: i=%0d v=%b st=%b fl=%b en=%b data=%h new_fails=%0d",
                     i, e_v, st, fl, wr_en, wr_data, (total_cnt - pass_cnt) - errs_before);
        end
        stall_in = 1'b0;
        flush_in = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire_count();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        total_cnt++;
        if (instret !== 64'd0) $display("FAIL instret_reset got %0d want 0", instret);
        else pass_cnt++;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 7'b0110011, 3'b000, 5'd1, 32'(k), 32'd0, 32'd0);
            step();
            if (k == 2) begin
                stall_in = 1'b1;
                step();
                step();
                stall_in = 1'b0;
                total_cnt++;
                if (instret !== 64'd2) $display("FAIL instret_stall got %0d want 2", instret);
                else pass_cnt++;
            end
        end
        drive(1'b0, 7'b0, 3'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        total_cnt++;
        if (instret !== 64'd5) $display("FAIL instret_count got %0d want 5", instret);
        else pass_cnt++;
        $display("retire: instret=%0d", instret);
    endtask
`endif

    initial begin
        test_reset();
        test_opcode_sweep();
        test_load_extract();
        test_errors();
        test_x0();
        test_stall_flush();
        test_async_reset();
        test_random();
`ifdef WB_RETIRE_CNT_EN
        test_retire_count();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
